// File: rtl/cpu_types_pkg.sv
// Shared console types: operand word, entry-state enum and seven-segment encoding.
// Pure declarations, no latency and no backpressure.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [6:0]  seg7_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } console_state_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    // Active-low segment pattern for one hex nibble.
    function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg7 = 7'h40;
            4'h1: hex_to_seg7 = 7'h79;
            4'h2: hex_to_seg7 = 7'h24;
            4'h3: hex_to_seg7 = 7'h30;
            4'h4: hex_to_seg7 = 7'h19;
            4'h5: hex_to_seg7 = 7'h12;
            4'h6: hex_to_seg7 = 7'h02;
            4'h7: hex_to_seg7 = 7'h78;
            4'h8: hex_to_seg7 = 7'h00;
            4'h9: hex_to_seg7 = 7'h10;
            4'hA: hex_to_seg7 = 7'h08;
            4'hB: hex_to_seg7 = 7'h03;
            4'hC: hex_to_seg7 = 7'h27;
            4'hD: hex_to_seg7 = 7'h21;
            4'hE: hex_to_seg7 = 7'h06;
            default: hex_to_seg7 = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/alu_fpga_console_key_debounce.sv
// Push-button synchroniser + debounce; one-cycle press pulse DEBOUNCE_CYCLES+2 edges
// after the key first samples low. No backpressure: pulses are fire-and-forget.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Differing level has now been stable long enough; only falling edges are events.
                cnt   <= '0;
                level <= sync2;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_fpga_console.sv
// Board console: debounced keys build operands A/B chunk by chunk, step aluop, show A, B or result.
// Updates land the edge after a key event; result/flags lag outport by one cycle. No backpressure.
module alu_fpga_console
    import cpu_types_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DIGITS          = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    input  logic [3:0]            KEY,
    input  logic [SW_W-1:0]       SW,
    output logic [DATA_W-1:0]     porta,
    output logic [DATA_W-1:0]     portb,
    output logic [3:0]            aluop,
    input  logic [DATA_W-1:0]     outport,
    input  logic                  negative,
    input  logic                  overflow,
    input  logic                  zero,
    output logic [DIGITS*7-1:0]   hex_n,
    output logic [2:0]            state_led,
    output logic [2:0]            flag_led
);
    localparam int CHUNKS = DATA_W / SW_W;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int NIBS   = DATA_W / 4;

    logic [3:0]       press;
    logic             unused_press;
    console_state_t   state;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] res_q;
    logic [2:0]       flag_q;
    logic [DATA_W-1:0] shown;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk     (CLOCK_50),
            .rst     (RST),
            .key_raw (KEY[k]),
            .press   (press[k])
        );
    end

    assign unused_press = press[2];

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state  <= ENTER_A;
            idx    <= '0;
            porta  <= '0;
            portb  <= '0;
            aluop  <= '0;
            res_q  <= '0;
            flag_q <= '0;
        end else begin
            if (state == RESULT) begin
                res_q  <= outport;
                flag_q <= {negative, overflow, zero};
            end
            if (press[3]) begin
                state <= ENTER_A;
                idx   <= '0;
                porta <= '0;
                portb <= '0;
                aluop <= '0;
            end else begin
                if (press[1]) aluop <= aluop + 4'd1;
                if (press[0]) begin
                    if (state == RESULT) begin
                        state <= ENTER_A;
                        idx   <= '0;
                    end else begin
                        for (int c = 0; c < CHUNKS; c++) begin
                            if (idx == IDX_W'(c)) begin
                                if (state == ENTER_A) porta[c*SW_W +: SW_W] <= SW;
                                else                  portb[c*SW_W +: SW_W] <= SW;
                            end
                        end
                        if (idx == IDX_W'(CHUNKS - 1)) begin
                            idx   <= '0;
                            state <= (state == ENTER_A) ? ENTER_B : RESULT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        case (state)
            ENTER_A: shown = porta;
            ENTER_B: shown = portb;
            default: shown = res_q;
        endcase
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        if (d < NIBS) begin : g_on
            assign hex_n[d*7 +: 7] = hex_to_seg7(shown[d*4 +: 4]);
        end else begin : g_off
            assign hex_n[d*7 +: 7] = SEG7_BLANK;
        end
    end

    assign state_led = {state == RESULT, state == ENTER_B, state == ENTER_A};
    assign flag_led  = (state == RESULT) ? flag_q : 3'b000;

endmodule
